// File: rtl/vec_sequencer_if.sv
// Sequencer-facing bus: program ROM fetch, data/coef RAM ports and register-file addressing.
interface vec_sequencer_if #(
  parameter int unsigned VEC_ID_WIDTH       = 3,
  parameter int unsigned REGFILE_ADDR_WIDTH = 4,
  parameter int unsigned DATA_ADDR_WIDTH    = 6,
  parameter int unsigned INSTR_ADDR_WIDTH   = 5
) ();
  localparam int unsigned INSTR_WIDTH = 2 + VEC_ID_WIDTH + 2 * REGFILE_ADDR_WIDTH + 3 * DATA_ADDR_WIDTH;

  logic                          en;
  logic                          prog;
  logic                          loop;
  logic [INSTR_WIDTH-1:0]        instr_word;
  logic                          fetch;
  logic [INSTR_ADDR_WIDTH-1:0]   pc;
  logic                          en_ram_pa;
  logic                          wr_ram_pa;
  logic                          en_ram_pb;
  logic                          wr_ram_pb;
  logic [DATA_ADDR_WIDTH-1:0]    data_addr;
  logic [DATA_ADDR_WIDTH-1:0]    coef_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] ar1;
  logic [REGFILE_ADDR_WIDTH-1:0] ar2;
  logic [REGFILE_ADDR_WIDTH-1:0] ard;
  logic                          rw;
  logic                          done;
  logic                          err;

  modport master (
    input  en, prog, loop, instr_word,
    output fetch, pc, en_ram_pa, wr_ram_pa, en_ram_pb, wr_ram_pb,
           data_addr, coef_addr, ar1, ar2, ard, rw, done, err
  );

  modport slave (
    output en, prog, loop, instr_word,
    input  fetch, pc, en_ram_pa, wr_ram_pa, en_ram_pb, wr_ram_pb,
           data_addr, coef_addr, ar1, ar2, ard, rw, done, err
  );
endinterface

// File: rtl/vec_sequencer.sv
// Multi-vector MAC sequencer: fetches allocation instructions and walks per-vector circular buffers.
module vec_sequencer #(
  parameter int unsigned VEC_ID_WIDTH       = 3,
  parameter int unsigned REGFILE_ADDR_WIDTH = 4,
  parameter int unsigned DATA_ADDR_WIDTH    = 6,
  parameter int unsigned INSTR_ADDR_WIDTH   = 5,
  parameter int unsigned PROG_LEN           = 32
) (
  input logic             clk,
  input logic             rst,
  vec_sequencer_if.master bus
);
  localparam int unsigned VW          = VEC_ID_WIDTH;
  localparam int unsigned RW          = REGFILE_ADDR_WIDTH;
  localparam int unsigned DW          = DATA_ADDR_WIDTH;
  localparam int unsigned AW          = INSTR_ADDR_WIDTH;
  localparam int unsigned NV          = 2 ** VW;
  localparam int unsigned LPTR_LSB    = DW;
  localparam int unsigned UPTR_LSB    = 2 * DW;
  localparam int unsigned EREG_LSB    = 3 * DW;
  localparam int unsigned RES_LSB     = 3 * DW + RW;
  localparam int unsigned VID_LSB     = 3 * DW + 2 * RW;
  localparam int unsigned UPSE_BIT    = VID_LSB + VW;
  localparam int unsigned LSTG_BIT    = UPSE_BIT + 1;
  localparam int unsigned INSTR_WIDTH = LSTG_BIT + 1;
  localparam logic [AW-1:0] PC_LAST   = AW'(PROG_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, RUN, WB, NEXT} state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d, ins_c;
  logic [DW-1:0]          k_q, k_d, idx_q, idx_d;
  logic [DW-1:0]          head_q [NV];
  logic [AW-1:0]          pc_q, pc_d;
  logic                   err_q, err_d;
  logic                   fetch_q, fetch_d, en_pa_q, en_pa_d, wr_pa_q, wr_pa_d;
  logic                   en_pb_q, en_pb_d, rw_q, rw_d, done_q, done_d;
  logic [DW-1:0]          data_addr_q, data_addr_d, coef_addr_q, coef_addr_d;
  logic [RW-1:0]          ar1_q, ar1_d, ar2_q, ar2_d, ard_q, ard_d;

  logic                   lstg_c, upse_c, head_upd_c;
  logic [VW-1:0]          vid_c;
  logic [RW-1:0]          res_c, ereg_c;
  logic [DW-1:0]          uptr_c, lptr_c, coef_c, lm1_c, head_c, k_nxt_c, idx_nxt_c;

  // During LOAD the fresh ROM word is decoded directly; afterwards the latched copy.
  assign ins_c     = (state_q == LOAD) ? bus.instr_word : ir_q;
  assign lstg_c    = ins_c[LSTG_BIT];
  assign upse_c    = ins_c[UPSE_BIT];
  assign vid_c     = ins_c[VID_LSB +: VW];
  assign res_c     = ins_c[RES_LSB +: RW];
  assign ereg_c    = ins_c[EREG_LSB +: RW];
  assign uptr_c    = ins_c[UPTR_LSB +: DW];
  assign lptr_c    = ins_c[LPTR_LSB +: DW];
  assign coef_c    = ins_c[0 +: DW];
  assign lm1_c     = uptr_c - lptr_c;
  assign head_c    = head_q[vid_c];
  assign k_nxt_c   = k_q + DW'(1);
  assign idx_nxt_c = (idx_q == '0) ? lm1_c : idx_q - DW'(1);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    k_d         = k_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    err_d       = err_q;
    fetch_d     = 1'b0;
    en_pa_d     = 1'b0;
    wr_pa_d     = 1'b0;
    en_pb_d     = 1'b0;
    rw_d        = 1'b0;
    done_d      = 1'b0;
    data_addr_d = data_addr_q;
    coef_addr_d = coef_addr_q;
    ar1_d       = ar1_q;
    ar2_d       = ar2_q;
    ard_d       = ard_q;
    head_upd_c  = 1'b0;

    case (state_q)
      IDLE: if (bus.en) begin
        state_d = FETCH;
        fetch_d = 1'b1;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d = ins_c;
        if (uptr_c < lptr_c) begin
          err_d   = 1'b1;
          done_d  = lstg_c;
          state_d = NEXT;
        end else if (upse_c) begin
          state_d = RUN;
        end else begin
          state_d     = WRITE;
          en_pa_d     = 1'b1;
          wr_pa_d     = 1'b1;
          data_addr_d = lptr_c + head_c;
        end
      end
      WRITE: state_d = RUN;
      RUN: if (k_q == lm1_c) begin
        state_d = WB;
        rw_d    = 1'b1;
        ard_d   = res_c;
      end else begin
        k_d         = k_nxt_c;
        idx_d       = idx_nxt_c;
        en_pa_d     = 1'b1;
        en_pb_d     = 1'b1;
        data_addr_d = lptr_c + idx_nxt_c;
        coef_addr_d = coef_c + k_nxt_c;
      end
      WB: begin
        state_d    = NEXT;
        head_upd_c = !upse_c;
        done_d     = lstg_c;
      end
      NEXT: begin
        pc_d = (lstg_c || pc_q == PC_LAST) ? '0 : pc_q + AW'(1);
        if (bus.en && (!lstg_c || bus.loop)) begin
          state_d = FETCH;
          fetch_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // First MAC cycle starts at the newest sample, coefficient base, fixed regfile operands.
    if (state_d == RUN && state_q != RUN) begin
      k_d         = '0;
      idx_d       = head_c;
      en_pa_d     = 1'b1;
      en_pb_d     = 1'b1;
      data_addr_d = lptr_c + head_c;
      coef_addr_d = coef_c;
      ar1_d       = res_c;
      ar2_d       = ereg_c;
    end

    if (bus.prog) begin
      state_d    = IDLE;
      pc_d       = '0;
      err_d      = 1'b0;
      fetch_d    = 1'b0;
      en_pa_d    = 1'b0;
      wr_pa_d    = 1'b0;
      en_pb_d    = 1'b0;
      rw_d       = 1'b0;
      done_d     = 1'b0;
      head_upd_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      head_q      <= '{default: '0};
      pc_q        <= '0;
      err_q       <= 1'b0;
      fetch_q     <= 1'b0;
      en_pa_q     <= 1'b0;
      wr_pa_q     <= 1'b0;
      en_pb_q     <= 1'b0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      data_addr_q <= '0;
      coef_addr_q <= '0;
      ar1_q       <= '0;
      ar2_q       <= '0;
      ard_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      err_q       <= err_d;
      fetch_q     <= fetch_d;
      en_pa_q     <= en_pa_d;
      wr_pa_q     <= wr_pa_d;
      en_pb_q     <= en_pb_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      data_addr_q <= data_addr_d;
      coef_addr_q <= coef_addr_d;
      ar1_q       <= ar1_d;
      ar2_q       <= ar2_d;
      ard_q       <= ard_d;
      if (bus.prog) head_q <= '{default: '0};
      else if (head_upd_c) head_q[vid_c] <= (head_c == lm1_c) ? '0 : head_c + DW'(1);
    end
  end

  assign bus.fetch     = fetch_q;
  assign bus.pc        = pc_q;
  assign bus.en_ram_pa = en_pa_q;
  assign bus.wr_ram_pa = wr_pa_q;
  assign bus.en_ram_pb = en_pb_q;
  assign bus.wr_ram_pb = 1'b0;
  assign bus.data_addr = data_addr_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.ar1       = ar1_q;
  assign bus.ar2       = ar2_q;
  assign bus.ard       = ard_q;
  assign bus.rw        = rw_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: doc/vec_sequencer.md
# vec_sequencer

Parametrised multi-vector sequencer for the sample-rate converter controller.
- Fetches allocation instructions from program memory and keeps one circular-buffer head pointer per vector.
- Drives the data/coefficient RAM port enables, the RAM addresses and the register-file addresses for one MAC pass per instruction.
- Supports program looping, an upsample (no-write) phase and a clean stop at instruction boundaries.
- Sits between program ROM, data/coef RAM and the datapath register file.

## Interface
- VEC_ID_WIDTH, 3: vector id width; 2**VEC_ID_WIDTH head pointers.
- REGFILE_ADDR_WIDTH, 4: register file address width.
- DATA_ADDR_WIDTH, 6: data/coef RAM address width.
- INSTR_ADDR_WIDTH, 5: program counter width.
- PROG_LEN, 32: program length; pc wraps to 0 after PROG_LEN-1.
- INSTR_WIDTH, derived as 2+VEC_ID_WIDTH+2*REGFILE_ADDR_WIDTH+3*DATA_ADDR_WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable.
- prog  in  1  programming mode: hold in IDLE, clear all head offsets.
- loop  in  1  1: restart at pc 0 after the last-stage instruction; 0: stop.
- instr_word  in  INSTR_WIDTH  fields MSB→LSB: lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr.
- fetch  out  1  program-memory read strobe.
- pc  out  INSTR_ADDR_WIDTH  program address.
- en_ram_pa, wr_ram_pa  out  1  data RAM port enable / write.
- en_ram_pb, wr_ram_pb  out  1  coef RAM port enable / write (wr_ram_pb always 0).
- data_addr, coef_addr  out  DATA_ADDR_WIDTH  RAM addresses.
- ar1, ar2, ard  out  REGFILE_ADDR_WIDTH  register-file read 1, read 2 and destination addresses.
- rw  out  1  register-file write strobe.
- done  out  1  one-cycle pulse after the last-stage instruction completes.
- err  out  1  sticky flag: illegal allocation seen; cleared by rst or prog.

## Operation
- **States:** IDLE, FETCH, LOAD, WRITE, RUN, WB, NEXT.
- **IDLE → FETCH:** when en=1 and prog=0.
- **FETCH:** fetch=1, pc valid. Memory returns instr_word on the next edge.
- **LOAD:** latch instr_word into the instruction register. len = data_uptr − data_lptr + 1.
  - If data_uptr < data_lptr: set err, skip the instruction, go to NEXT.
- **WRITE:** taken only when upse_f=0, otherwise LOAD → RUN.
  - en_ram_pa=1, wr_ram_pa=1, data_addr = data_lptr + head[vector_id].
- **RUN:** lasts len cycles, k = 0..len−1.
  - en_ram_pa=1, en_ram_pb=1.
  - data_addr = data_lptr + ((head − k) mod len), i.e. newest sample first, wrapping inside [lptr, uptr].
  - coef_addr = coef_ptr + k.
  - ar1 = result_reg, ar2 = error_reg.
- **WB:** one cycle, rw=1, ard = result_reg.
  - If the instruction wrote a sample: head[vector_id] ← (head+1 == len) ? 0 : head+1.
- **NEXT:**
  - lstg_f=1 or pc = PROG_LEN−1: pc ← 0.
  - lstg_f=1 additionally pulses done.
  - Otherwise pc ← pc+1.
  - Next state is FETCH if en=1 and (lstg_f=0 or loop=1); otherwise IDLE.
- **en deassertion:** en=0 mid-instruction completes the instruction, then parks in IDLE. pc is preserved and resumes on the next en=1.
- **prog=1:** forces IDLE from any state at the next edge. Clears all head offsets, pc and err.
- **Address width:** address arithmetic is modulo 2**DATA_ADDR_WIDTH.
- **Idle outputs:** addresses and register-file addresses hold their last value; all strobes are 0.

## Timing
- **Reset:** all outputs 0 (fetch, pc, enables, writes, addresses, ar1/ar2/ard, rw, done, err); state IDLE; heads 0.
- **Cycles per instruction:** FETCH + LOAD + (WRITE) + len + WB + NEXT, i.e. 5+len with write, 4+len with upse_f=1.
- **Instruction capture:** instr_word is sampled at the end of LOAD, exactly one cycle after the fetch cycle.
- **Registered outputs:** all outputs change only on clk rising edge, except the async reset clear.
- **Simultaneous events:** prog has priority over en. Reset mid-RUN aborts immediately; head pointers are not updated.

## Test plan
- **Single instruction:** reset, load a one-instruction program: lstg=1, upse=0, vid=0, result=3, error=5, lptr=8, uptr=11, coef=16; en=1, loop=0.
  - Expect fetch at pc 0, then a write to data_addr 8.
  - Then RUN data_addr 8,11,10,9 with coef_addr 16..19.
  - Then rw=1 with ard=3, then done, then IDLE; 9 cycles total.
- **Head wrap:** repeat the same program 4 times with loop=1.
  - Write addresses 8,9,10,11, then 8 again on the 5th pass.
  - 5th pass RUN sequence is 8,11,10,9.
- **Upsample phase:** instruction with upse=1.
  - No wr_ram_pa pulse; head unchanged; 8 cycles.
- **Illegal allocation:** lptr=12, uptr=4.
  - err=1, no RAM enables, pc advances; err stays set until prog.
- **Multi-vector, PROG_LEN wrap:** program of PROG_LEN instructions alternating vid 0/1, none lstg, loop=1.
  - Independent heads per vector; pc wraps 31→0.
  - Drop en mid-RUN: the instruction finishes, then IDLE with pc held.
- **Reset during RUN:** all outputs 0 immediately; on restart, the head for that vector is still 0.
